// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel off/solid/blink/chase on a shared tick timebase.
// Define LED_PWM_EN to build the PWM dimming stage driven by DUTY.
module led_pattern_gen #(
  parameter int CHANNELS = 10,
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int PERIOD_W = 12,
  parameter int PWM_W    = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic [2*CHANNELS-1:0] MODE,
  input  logic [PERIOD_W-1:0]   HALF_PERIOD,
  input  logic [PWM_W-1:0]      DUTY,
  input  logic                  SYNC,
  output logic [CHANNELS-1:0]   LEDR
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int POS_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_SOLID = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_CHASE = 2'b11
  } led_mode_e;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PERIOD_W-1:0] hp_cnt_q, hp_cnt_d;
  logic                phase_q, phase_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [CHANNELS-1:0] led_q, led_d;
  logic [PERIOD_W-1:0] hp_eff;
  logic                tick;
  logic                terminal;
  logic                pwm_on;

  assign tick     = (pre_q == PRE_W'(DIV - 1));
  assign hp_eff   = (HALF_PERIOD == '0) ? PERIOD_W'(1) : HALF_PERIOD;
  // >= rather than == so a shrinking HALF_PERIOD ends the period on the next tick
  assign terminal = tick && (hp_cnt_q >= (hp_eff - PERIOD_W'(1)));

  always_comb begin
    pre_d    = tick ? '0 : pre_q + PRE_W'(1);
    hp_cnt_d = hp_cnt_q;
    phase_d  = phase_q;
    pos_d    = pos_q;
    if (terminal) begin
      hp_cnt_d = '0;
      phase_d  = ~phase_q;
      if (CHANNELS > 1) begin
        pos_d = (pos_q == POS_W'(CHANNELS - 1)) ? '0 : pos_q + POS_W'(1);
      end
    end else if (tick) begin
      hp_cnt_d = hp_cnt_q + PERIOD_W'(1);
    end
    if (SYNC) begin
      pre_d    = '0;
      hp_cnt_d = '0;
      phase_d  = 1'b1;
      pos_d    = '0;
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = SYNC ? '0 : pwm_cnt_q + PWM_W'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_on = (pwm_cnt_q < DUTY) || (DUTY == '1);
`else
  logic unused_duty;
  assign unused_duty = ^DUTY;
  assign pwm_on      = 1'b1;
`endif

  always_comb begin
    led_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (led_mode_e'(MODE[2*i +: 2]))
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_SOLID: led_d[i] = pwm_on;
        MODE_BLINK: led_d[i] = phase_q & pwm_on;
        MODE_CHASE: led_d[i] = (pos_q == POS_W'(i)) & pwm_on;
        default:    led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_q    <= '0;
      hp_cnt_q <= '0;
      phase_q  <= 1'b0;
      pos_q    <= '0;
      led_q    <= '0;
    end else begin
      pre_q    <= pre_d;
      hp_cnt_q <= hp_cnt_d;
      phase_q  <= phase_d;
      pos_q    <= pos_d;
      led_q    <= led_d;
    end
  end

  assign LEDR = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with a 10-cycle tick, 4 channels and 4-bit PWM.
module tb_led_pattern_gen;

  logic       CLOCK_50;
  logic       RESET_N;
  logic [7:0] MODE;
  logic [3:0] HALF_PERIOD;
  logic [3:0] DUTY;
  logic       SYNC;
  logic [3:0] LEDR;

  int total;
  int bad;
  int highs;

  led_pattern_gen #(
    .CHANNELS(4),
    .CLK_HZ(100),
    .TICK_HZ(10),
    .PERIOD_W(4),
    .PWM_W(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .MODE(MODE),
    .HALF_PERIOD(HALF_PERIOD),
    .DUTY(DUTY),
    .SYNC(SYNC),
    .LEDR(LEDR)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 ns past the last one
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic pulseSync();
    SYNC = 1'b1;
    applyStimulus(1);
    SYNC = 1'b0;
  endtask

  task automatic countHighs(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      applyStimulus(1);
      if (LEDR[0]) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total       = 0;
    bad         = 0;
    RESET_N     = 1'b0;
    MODE        = 8'h55;
    HALF_PERIOD = 4'd3;
    DUTY        = 4'hF;
    SYNC        = 1'b0;

    $display("[TB] reset behaviour");
    applyStimulus(3);
    checkOutput("reset_hold", LEDR, 4'h0);
    RESET_N = 1'b1;
    applyStimulus(1);
    checkOutput("first_edge_solid", LEDR, 4'hF);
    applyStimulus(12);
    checkOutput("solid_running", LEDR, 4'hF);
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("async_reset", LEDR, 4'h0);
    #2;
    RESET_N = 1'b1;
    applyStimulus(1);
    checkOutput("post_reset_edge", LEDR, 4'hF);

    $display("[TB] blink half-period 3");
    MODE = 8'hAA;
    HALF_PERIOD = 4'd3;
    pulseSync();
    applyStimulus(1);
    checkOutput("blink_k1", LEDR, 4'hF);
    applyStimulus(29);
    checkOutput("blink_k30", LEDR, 4'hF);
    applyStimulus(1);
    checkOutput("blink_k31", LEDR, 4'h0);
    applyStimulus(29);
    checkOutput("blink_k60", LEDR, 4'h0);
    applyStimulus(1);
    checkOutput("blink_k61", LEDR, 4'hF);

    $display("[TB] chase with wrap");
    MODE = 8'hFF;
    HALF_PERIOD = 4'd1;
    pulseSync();
    applyStimulus(1);
    checkOutput("chase_k1", LEDR, 4'b0001);
    applyStimulus(9);
    checkOutput("chase_k10", LEDR, 4'b0001);
    applyStimulus(1);
    checkOutput("chase_k11", LEDR, 4'b0010);
    applyStimulus(10);
    checkOutput("chase_k21", LEDR, 4'b0100);
    applyStimulus(10);
    checkOutput("chase_k31", LEDR, 4'b1000);
    applyStimulus(10);
    checkOutput("chase_wrap_k41", LEDR, 4'b0001);

    $display("[TB] half-period zero");
    MODE = 8'hAA;
    HALF_PERIOD = 4'd0;
    pulseSync();
    applyStimulus(10);
    checkOutput("hp0_k10", LEDR, 4'hF);
    applyStimulus(1);
    checkOutput("hp0_k11", LEDR, 4'h0);
    applyStimulus(10);
    checkOutput("hp0_k21", LEDR, 4'hF);

    $display("[TB] mid-count shrink 8 to 2");
    HALF_PERIOD = 4'd8;
    pulseSync();
    applyStimulus(55);
    checkOutput("shrink_k55", LEDR, 4'hF);
    HALF_PERIOD = 4'd2;
    applyStimulus(5);
    checkOutput("shrink_k60", LEDR, 4'hF);
    applyStimulus(1);
    checkOutput("shrink_k61", LEDR, 4'h0);

    $display("[TB] sync on terminal tick");
    MODE = 8'hBF;
    HALF_PERIOD = 4'd3;
    pulseSync();
    applyStimulus(29);
    checkOutput("coinc_k29", LEDR, 4'b1001);
    pulseSync();
    applyStimulus(1);
    checkOutput("coinc_k31", LEDR, 4'b1001);
    applyStimulus(29);
    checkOutput("coinc_k60", LEDR, 4'b1001);
    applyStimulus(1);
    checkOutput("coinc_k61", LEDR, 4'b0010);

    MODE = 8'h55;
`ifdef LED_PWM_EN
    $display("[TB] pwm dimming");
    DUTY = 4'd4;
    pulseSync();
    for (int k = 1; k <= 32; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("pwm4_k%0d", k), LEDR, (((k - 1) % 16) < 4) ? 4'hF : 4'h0);
    end
    DUTY = 4'd0;
    applyStimulus(1);
    countHighs(16, highs);
    checkOutput("pwm_duty0_highs", highs, 0);
    DUTY = 4'hF;
    applyStimulus(1);
    countHighs(16, highs);
    checkOutput("pwm_dutyF_highs", highs, 16);
`else
    $display("[TB] duty ignored without pwm");
    DUTY = 4'd0;
    applyStimulus(1);
    countHighs(16, highs);
    checkOutput("nopwm_duty0_highs", highs, 16);
    DUTY = 4'd4;
    applyStimulus(1);
    countHighs(16, highs);
    checkOutput("nopwm_duty4_highs", highs, 16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised multi-channel LED driver for the DE1-SoC LED bank, the successor to the single-LED blinker. Each of CHANNELS outputs independently selects off, solid, blink or chase mode. All channels share a millisecond-scale timebase, so they blink in phase. An optional PWM stage dims every lit LED to a programmable brightness. The block sits between user/control logic (switches or a register file) and the LEDR pins.

## Interface
Parameters:
- CHANNELS, 10: number of LED outputs (≥1).
- CLK_HZ, 50_000_000: input clock frequency.
- TICK_HZ, 1000: timebase tick rate. CLK_HZ/TICK_HZ must be an integer ≥2.
- PERIOD_W, 12: width of the half-period field, in ticks.
- PWM_W, 8: PWM counter/duty width.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- MODE  in  2*CHANNELS  per-channel mode; bits [2i+1:2i] for channel i. 00 OFF, 01 SOLID, 10 BLINK, 11 CHASE.
- HALF_PERIOD  in  PERIOD_W  blink half-period / chase step, in ticks. 0 is treated as 1.
- DUTY  in  PWM_W  brightness for lit channels.
- SYNC  in  1  single-cycle pulse; restarts timebase, blink phase and chase position.
- LEDR  out  CHANNELS  LED drive, registered, active-high.

## Operation
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1 and wraps. `tick` is asserted for the one cycle in which the count equals the terminal value.
- Half-period counter: advances on `tick`.
  - Terminal condition: count ≥ max(HALF_PERIOD,1)-1 while `tick` is asserted.
  - At terminal: the counter clears to 0, `phase` toggles, and the chase position `pos` advances.
  - `pos` wraps from CHANNELS-1 to 0. For CHANNELS=1, `pos` stays 0.
  - The ≥ compare means that lowering HALF_PERIOD mid-count terminates the period on the next tick. There is no stall.
- PWM, only with LED_PWM_EN:
  - Free-running PWM_W counter `pwm_cnt`, incremented every cycle, wraps at 2^PWM_W.
  - `pwm_on` = (pwm_cnt < DUTY) | (DUTY == all ones).
  - DUTY=0 means lit channels stay dark.
- Per-channel lit term:
  - OFF → 0.
  - SOLID → 1.
  - BLINK → `phase`.
  - CHASE → (pos == i).
- Output: LEDR[i] <= lit_i & pwm_on.
- SYNC:
  - In the cycle after SYNC is sampled high: prescaler = 0, half-period counter = 0, `phase` = 1, `pos` = 0, `pwm_cnt` = 0.
  - SYNC takes priority over a coincident `tick` or terminal event.
- Reset (RESET_N low, asynchronous): all counters 0, `phase` = 0, `pos` = 0, LEDR = 0.
  - Reset asserted mid-period discards all progress.
  - After release, the first tick comes CLK_HZ/TICK_HZ cycles after the first active edge.

## Timing
- MODE, DUTY and SYNC effects are visible on LEDR exactly 1 cycle after they are sampled. There is no input synchronisation; callers synchronise asynchronous switches.
- Blink full period = 2·max(HALF_PERIOD,1)·CLK_HZ/TICK_HZ cycles, duty 50%.
- `phase` toggle and `pos` advance occur on the same edge. LEDR reflects them one cycle later.
- Chase step = max(HALF_PERIOD,1) ticks. A full chase cycle = CHANNELS steps.
- A HALF_PERIOD change is sampled only on `tick` cycles. Between ticks it has no effect.
- PWM frequency = CLK_HZ / 2^PWM_W, about 195 kHz at defaults.

## Configuration
- LED_PWM_EN:
  - Defined: PWM counter and `pwm_on` are built, and DUTY controls brightness.
  - Undefined: no PWM counter is synthesised, `pwm_on` is constant 1, and DUTY is ignored. The DUTY port remains so the port list is unchanged.

## Test plan
Bench parameters: CLK_HZ=100, TICK_HZ=10, CHANNELS=4, PERIOD_W=4, PWM_W=4.

- Reset check: hold RESET_N low mid-count with MODE all SOLID → LEDR=0 immediately (asynchronously). After release, LEDR=4'hF one cycle after the first edge (LED_PWM_EN off, or DUTY=4'hF).
- Blink: MODE=8'b10_10_10_10, HALF_PERIOD=3, SYNC pulse → LEDR=4'hF for 30 cycles, 4'h0 for 30 cycles, repeating.
- Chase with wrap: MODE all CHASE, HALF_PERIOD=1, SYNC → LEDR walks 0001→0010→0100→1000→0001, 10 cycles per step.
- HALF_PERIOD=0 and mid-count shrink:
  - HALF_PERIOD=0 → blink toggles every 10 cycles.
  - Change 8→2 when the count is at 5 → toggle on the next tick.
- SYNC coincident with terminal tick → `phase`=1 and `pos`=0 win. The next toggle occurs a full half-period later.
- PWM (LED_PWM_EN defined), SOLID:
  - DUTY=4 → LEDR high 4 of every 16 cycles.
  - DUTY=0 → always low.
  - DUTY=4'hF → always high.
